// File: rtl/axi_wr_slave.sv
// axi_wr_slave: AXI4 write-channel slave (AW/W/B) backed by a word memory.
// Accepts one burst at a time: latches the AW request, absorbs W beats into
// memory with per-byte lane enables, then returns a single B response.
//
// Ports:
//   CLK, RESET            rising-edge clock, synchronous active-high reset
//   AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID -> AWREADY   address channel
//   WDATA/WLAST/WVALID -> WREADY                      data channel
//   BRESP/BVALID <- BREADY                            response channel
//   DBG_IDX -> DBG_DATA   combinational side-band word read of the memory
module axi_wr_slave #(
    parameter  int DEPTH  = 256,
    localparam int AW_IDX = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [15:0]       AWADDR,
    input  logic [7:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [AW_IDX-1:0] DBG_IDX,
    output logic [31:0]       DBG_DATA
);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t      state;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  cnt;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        err;      // sticky: any error seen in this burst
    logic        dec_err;  // request itself was illegal; suppresses all writes

    logic [31:0] mem [DEPTH];

    // Handshake readies are pure state decodes, held low during reset.
    assign AWREADY  = (state == IDLE) && !RESET;
    assign WREADY   = (state == DATA) && !RESET;
    assign BVALID   = (state == RESP) && !RESET;
    assign BRESP    = (BVALID && err) ? 2'b10 : 2'b00;
    assign DBG_DATA = mem[DBG_IDX];

    logic w_hs;
    assign w_hs = WVALID && WREADY;

    // Request legality, evaluated on the raw AW inputs at accept time.
    logic aw_bad;
    always_comb begin
        aw_bad = 1'b0;
        if (AWSIZE > 3'd2) aw_bad = 1'b1;
        if (AWBURST == 2'd3) aw_bad = 1'b1;
        if (AWBURST == 2'd2 && !(AWLEN == 8'd1 || AWLEN == 8'd3 ||
                                 AWLEN == 8'd7 || AWLEN == 8'd15))
            aw_bad = 1'b1;
        case (AWSIZE)
            3'd1:    if (AWADDR[0]) aw_bad = 1'b1;
            3'd2:    if (AWADDR[1:0] != 2'd0) aw_bad = 1'b1;
            default: ;
        endcase
    end

    // Beat address arithmetic and byte-lane selection.
    logic [15:0] step;
    logic [15:0] wrap_mask;
    logic [15:0] next_addr;
    logic [3:0]  lanes;
    logic        in_range;
    logic [AW_IDX-1:0] word;

    always_comb begin
        step      = 16'd1 << size;
        wrap_mask = ((16'(len) + 16'd1) << size) - 16'd1;
        case (burst)
            2'd0:    next_addr = addr;
            2'd2:    next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default: next_addr = addr + step;
        endcase
        // Narrow sizes are aligned whenever a write is permitted, so a
        // simple shift by the byte offset lands on the right lanes.
        case (size)
            3'd0:    lanes = 4'b0001 << addr[1:0];
            3'd1:    lanes = 4'b0011 << addr[1:0];
            default: lanes = 4'b1111;
        endcase
        in_range = 32'(addr) < 32'(DEPTH * 4);
        word     = addr[AW_IDX+1:2];
    end

    // Memory has no reset: contents survive RESET, including partial bursts.
    always_ff @(posedge CLK) begin
        if (w_hs && !dec_err && in_range) begin
            for (int i = 0; i < 4; i++)
                if (lanes[i]) mem[word][8*i +: 8] <= WDATA[8*i +: 8];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            addr    <= '0;
            len     <= '0;
            cnt     <= '0;
            size    <= '0;
            burst   <= '0;
            err     <= 1'b0;
            dec_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (AWVALID) begin
                    addr    <= AWADDR;
                    len     <= AWLEN;
                    size    <= AWSIZE;
                    burst   <= AWBURST;
                    cnt     <= '0;
                    dec_err <= aw_bad;
                    err     <= aw_bad;
                    state   <= DATA;
                end
                DATA: if (WVALID) begin
                    addr <= next_addr;
                    if (!in_range) err <= 1'b1;
                    if (cnt == len) begin
                        state <= RESP;
                        if (!WLAST) err <= 1'b1;
                    end else if (WLAST) begin
                        // Early WLAST closes the burst; missing beats are not awaited.
                        err   <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: if (BREADY) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
